// File: rtl/next_pc_gen_pkg.sv
// Shared front-end types for the next-PC generator.
// Redirect selects, BRU resolve bundle and PC alignment helper.
package next_pc_gen_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_PRD,
    SEL_RESTORE,
    SEL_BRU
  } pc_sel_e;

  typedef struct packed {
    logic            valid;
    logic            prd_taken;
    logic            taken;
    logic [XLEN-1:0] target;
  } bru_resolve_t;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } branch_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_gen_ckpt_fifo.sv
// Checkpoint FIFO of fall-through PCs for in-flight taken predictions.
// Clear wins over push/pop; push on full and pop on empty are dropped.
module pc_ckpt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC generator: BRU mispredict > predictor taken > sequential.
// Optional return stack enabled with NEXT_PC_RAS_EN.
module next_pc_gen
  import next_pc_gen_pkg::*;
#(
  parameter int unsigned     FETCH_W    = 2,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     CKPT_DEPTH = 4,
  parameter int unsigned     RAS_DEPTH  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_stall,
  input  logic                        i_prd_taken,
  input  logic [XLEN-1:0]             i_prd_target,
  input  logic                        i_prd_call,
  input  logic                        i_prd_ret,
  input  logic                        i_bru_valid,
  input  logic                        i_bru_prd_taken,
  input  logic                        i_bru_taken,
  input  logic [XLEN-1:0]             i_bru_target,
  output logic [XLEN-1:0]             o_pc,
  output logic                        o_flush,
  output logic                        o_ckpt_full,
  output logic [$clog2(CKPT_DEPTH):0] o_ckpt_cnt
);

  localparam int unsigned CW = $clog2(CKPT_DEPTH) + 1;
  localparam logic [XLEN-1:0] SEQ_INC = XLEN'(4 * FETCH_W);

  bru_resolve_t    bru;
  pc_sel_e         sel;
  logic            miss_nt;
  logic            miss_t;
  logic            flush;
  logic            prd_ok;
  logic            pop_req;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] prd_pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ckpt_head;
  logic [CW-1:0]   ckpt_cnt;
  logic            ckpt_full;
  logic            ckpt_empty;

  assign bru = '{
    valid:     i_bru_valid,
    prd_taken: i_bru_prd_taken,
    taken:     i_bru_taken,
    target:    i_bru_target
  };

  assign miss_nt = bru.valid & bru.taken & ~bru.prd_taken;
  assign miss_t  = bru.valid & ~bru.taken & bru.prd_taken;
  assign flush   = miss_nt | miss_t;
  assign prd_ok  = ~i_stall & i_prd_taken & ~ckpt_full;
  assign pop_req = bru.valid & bru.prd_taken & ~flush;
  assign seq_pc  = o_pc + SEQ_INC;

  assign o_flush     = flush;
  assign o_ckpt_full = ckpt_full;
  assign o_ckpt_cnt  = ckpt_cnt;

`ifdef NEXT_PC_RAS_EN
  localparam int unsigned RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [RW-1:0]   ras_ptr;
  logic [RW-1:0]   ras_top;
  logic [RW:0]     ras_cnt;
  logic            ras_hit;
  logic            ras_push;
  logic            ras_act;

  assign ras_act  = (sel == SEL_PRD);
  assign ras_top  = ras_ptr - RW'(1);
  assign ras_hit  = i_prd_ret & (ras_cnt != '0);
  assign ras_push = i_prd_call & ~i_prd_ret;
  assign prd_pc   = ras_hit ? ras_mem[ras_top] : i_prd_target;

  // Return-stack storage; overflow overwrites the oldest slot.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && ras_act && ras_push) begin
      ras_mem[ras_ptr] <= seq_pc;
    end
  end

  // Return-stack pointer; flushes drop it without repair.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || flush) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_act && ras_hit) begin
      ras_ptr <= ras_top;
      ras_cnt <= ras_cnt - 1'b1;
    end else if (ras_act && ras_push) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
    end
  end
`else
  logic unused_ras;

  assign unused_ras = i_prd_call ^ i_prd_ret ^ (RAS_DEPTH == 0);
  assign prd_pc     = i_prd_target;
`endif

  // Redirect source select; terms are mutually exclusive.
  always_comb begin
    sel = SEL_SEQ;
    unique case (1'b1)
      miss_nt:         sel = SEL_BRU;
      miss_t:          sel = SEL_RESTORE;
      prd_ok & ~flush: sel = SEL_PRD;
      default:         sel = SEL_SEQ;
    endcase
  end

  // Next-PC mux; sequential with stall means hold.
  always_comb begin
    next_pc = o_pc;
    unique case (sel)
      SEL_BRU:     next_pc = bru.target;
      SEL_RESTORE: next_pc = ckpt_head;
      SEL_PRD:     next_pc = prd_pc;
      default:     next_pc = i_stall ? o_pc : seq_pc;
    endcase
    next_pc = align_pc(next_pc);
  end

  // Fetch PC register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pc <= align_pc(RESET_PC);
    end else begin
      o_pc <= next_pc;
    end
  end

  pc_ckpt_fifo #(
    .DEPTH (CKPT_DEPTH),
    .WIDTH (XLEN)
  ) u_ckpt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (sel == SEL_PRD),
    .pop   (pop_req & ~ckpt_empty),
    .clear (flush),
    .wdata (seq_pc),
    .head  (ckpt_head),
    .count (ckpt_cnt),
    .full  (ckpt_full),
    .empty (ckpt_empty)
  );

  pop_on_empty: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(pop_req && ckpt_empty)
  );

endmodule

// File: doc/next_pc_gen.md
Name: next_pc_gen

Overview:
- Parametrised next-PC generator for the superscalar front end; successor to the fixed 2-wide PC unit.
- Configurable fetch width and reset vector; replaces the single restore register with a checkpoint FIFO of fall-through PCs for several in-flight predicted-taken branches.
- Applies explicit redirect priority: BRU mispredict > predictor taken > sequential. Feeds the fetch stage; fed by the predictor (BTB/BHT) and the BRU.

Parameters:
- FETCH_W, 2, instructions per fetch group; sequential increment = 4*FETCH_W.
- RESET_PC, 32'h0000_0000, o_pc value after reset.
- CKPT_DEPTH, 4, recovery-PC FIFO entries (power of 2, >=2).
- RAS_DEPTH, 8, return-stack entries (power of 2); used only with the optional feature.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_stall  in  1  hold o_pc; no checkpoint push. A BRU redirect still applies.
- i_prd_taken  in  1  predictor hit and taken for the current o_pc group.
- i_prd_target  in  32  predicted target.
- i_prd_call  in  1  predicted branch is a call; used only with RAS_EN.
- i_prd_ret  in  1  predicted branch is a return; used only with RAS_EN.
- i_bru_valid  in  1  BRU resolved a branch this cycle; resolution is in program order.
- i_bru_prd_taken  in  1  resolved branch had been predicted taken, so it owns the FIFO head.
- i_bru_taken  in  1  actual outcome.
- i_bru_target  in  32  actual target.
- o_pc  out  32  current fetch PC.
- o_flush  out  1  mispredict detected this cycle; active high, combinational.
- o_ckpt_full  out  1  FIFO full.
- o_ckpt_cnt  out  $clog2(CKPT_DEPTH)+1  occupancy.

Behaviour:
- Reset (sync, i_rst_n=0 at posedge):
  - o_pc=RESET_PC; FIFO and RAS pointers and counts=0.
  - o_flush=0, o_ckpt_full=0, o_ckpt_cnt=0.
- Mispredict classes, when i_bru_valid=1:
  - miss_nt = i_bru_taken & ~i_bru_prd_taken.
  - miss_t = ~i_bru_taken & i_bru_prd_taken.
  - o_flush = miss_nt | miss_t.
  - A taken/taken target mismatch is not detected here; the BRU reports it as miss_nt with the correct target.
- Next-PC priority, registered at posedge; latency 1 cycle for every source:
  1. miss_nt: next = i_bru_target.
  2. miss_t: next = FIFO head.
  3. ~i_stall & i_prd_taken & ~o_ckpt_full: next = i_prd_target (or the RAS top when a return is predicted with RAS_EN).
  4. ~i_stall: next = o_pc + 4*FETCH_W, 32-bit wrap, carry dropped.
  5. Otherwise hold.
- FIFO:
  - Push o_pc+4*FETCH_W when case 3 is taken.
  - Pop when i_bru_valid & i_bru_prd_taken & ~o_flush.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - On o_flush: clear the FIFO (count=0, pointers=0) in the same edge, after reading the head for case 2. All remaining entries belong to younger, squashed branches.
  - Full with a predicted-taken group: prediction suppressed, fall back to sequential (case 4), no push. o_ckpt_full=1 while count==CKPT_DEPTH.
  - Pop with empty FIFO is illegal; assertion in simulation, state unchanged.
- Reset mid-operation overrides all redirects and pushes.
- Bits [1:0] of every next-PC source are forced to 0.

Optional Feature:
- Macro NEXT_PC_RAS_EN, defined: return address stack with RAS_DEPTH entries.
  - Call: on case 3 with i_prd_call, push o_pc+4*FETCH_W.
  - Return: on case 3 with i_prd_ret and RAS non-empty, next = RAS top and pop. If the RAS is empty, use i_prd_target.
  - Overflow wraps the pointer and overwrites the oldest entry.
  - On o_flush, RAS count and pointer reset to 0; no repair.
- Undefined: i_prd_call and i_prd_ret are ignored; no RAS storage is synthesised.

Decomposition:
- Shared package:
  - XLEN=32 constant.
  - pc_sel_e enum: SEL_SEQ, SEL_PRD, SEL_RESTORE, SEL_BRU.
  - Typedef bru_resolve_t bundling valid/prd_taken/taken/target.
  - Existing branch_t is unchanged.
- One sub-module: pc_ckpt_fifo, parametrised by DEPTH and WIDTH, with push/pop/clear and count/full/empty. The RAS is inline under the macro.

Test Plan:
- Reset, RESET_PC=32'h100, FETCH_W=2, no stall, 3 cycles -> o_pc 0x100, 0x108, 0x110, 0x118.
- Predicted taken at o_pc=0x200, target 0x400 -> next o_pc=0x400, FIFO count 1 with head 0x208. Then BRU resolves prd_taken=1, taken=0 -> o_flush=1, next o_pc=0x208, count=0.
- Four predicted takens with CKPT_DEPTH=4, then a fifth at 0x500 -> o_ckpt_full=1, next o_pc=0x508, count stays 4. Same cycle BRU correct resolve (prd_taken=1, taken=1) -> prediction still suppressed, count 3.
- i_stall=1 with i_prd_taken=1 and BRU miss_nt target 0x800 in the same cycle -> o_pc=0x800 next cycle, FIFO cleared, no push.
- o_pc=32'hFFFF_FFF8, FETCH_W=2, no redirect -> next o_pc=0x0000_0000.
- NEXT_PC_RAS_EN: call at 0x300 to target 0x600, then return at 0x610 -> next o_pc=0x308. Second return with empty RAS and i_prd_target=0x700 -> 0x700.
